// File: rtl/paralelo_serial_param_pkg.sv
// Shared types and constants for the parametrised parallel-to-serial transmitter.
package paralelo_serial_param_pkg;

  // Transmitter phases: alignment filler after reset, then normal data service.
  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Default COM symbol used as filler/alignment word.
  localparam logic [7:0] COM_SYM = 8'hBC;

  // Counter width able to hold 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/paralelo_serial_param_contador_bits.sv
// Bit-position counter for one serial word: 0..WIDTH-1, wrapping.
module contador_bits
  import paralelo_serial_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic [cnt_width(WIDTH)-1:0]    o_bit_cnt,
  output logic                           o_last_bit
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign o_bit_cnt  = r_cnt;
  assign o_last_bit = w_last;

  // Advance one position per bit clock, wrap after the last bit of the word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parametrised parallel-to-serial transmitter with a one-word holding buffer,
// valid/ready input handshake and post-reset alignment filler.
module paralelo_serial_param
  import paralelo_serial_param_pkg::*;
#(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(COM_SYM),
  parameter int unsigned     SYNC_WORDS = 4,
  parameter bit              MSB_FIRST  = 1'b1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out_serial,
  output logic             word_start,
  output logic             sending_data,
  output logic             sync_done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned SW = cnt_width(SYNC_WORDS);

  logic [CW-1:0]    w_bit_cnt;
  logic             w_last_bit;
  logic             w_pre_last;
  logic             w_accept;
  logic             w_hold_full_nxt;
  logic             w_go_active;
  logic             w_ready_nxt;
  logic [CW-1:0]    w_idx;
  logic             w_cur_bit;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_is_data;
  logic [SW-1:0]    r_sync_cnt;
  logic             r_out_serial;
  logic             r_word_start;
  logic             r_sending_data;
  logic             r_sync_done;
  logic             r_ready_out;

  contador_bits #(
    .WIDTH(WIDTH)
  ) u_contador_bits (
    .i_clk      (clk_32f),
    .i_rst      (reset),
    .o_bit_cnt  (w_bit_cnt),
    .o_last_bit (w_last_bit)
  );

  // Select the bit of the current word that goes out this cycle.
  always_comb begin
    w_idx     = MSB_FIRST ? (CW'(WIDTH - 1) - w_bit_cnt) : w_bit_cnt;
    w_cur_bit = r_shift[w_idx];
  end

  // Handshake and look-ahead terms so ready_out can be registered.
  always_comb begin
    w_pre_last      = (w_bit_cnt == CW'(WIDTH - 2));
    w_accept        = valid_in & r_ready_out;
    w_hold_full_nxt = w_accept | (r_hold_full & ~w_last_bit);
    w_go_active     = (r_state == ST_SYNC) & w_last_bit &
                      (r_sync_cnt == SW'(SYNC_WORDS - 1));
    w_ready_nxt     = ((r_state == ST_ACTIVE) | w_go_active) &
                      (~w_hold_full_nxt | w_pre_last);
  end

  // FSM, hold/shift registers and bit-aligned output registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state        <= ST_SYNC;
      r_shift        <= IDLE_SYM;
      r_hold         <= '0;
      r_hold_full    <= 1'b0;
      r_is_data      <= 1'b0;
      r_sync_cnt     <= '0;
      r_out_serial   <= 1'b0;
      r_word_start   <= 1'b0;
      r_sending_data <= 1'b0;
      r_sync_done    <= 1'b0;
      r_ready_out    <= 1'b0;
    end else begin
      r_out_serial   <= w_cur_bit;
      r_word_start   <= (w_bit_cnt == '0);
      r_sending_data <= r_is_data;
      r_ready_out    <= w_ready_nxt;
      r_hold_full    <= w_hold_full_nxt;
      if (w_accept) begin
        r_hold <= data_in;
      end
      // Load edge: held word if any, otherwise filler.
      if (w_last_bit) begin
        if ((r_state == ST_ACTIVE) && r_hold_full) begin
          r_shift   <= r_hold;
          r_is_data <= 1'b1;
        end else begin
          r_shift   <= IDLE_SYM;
          r_is_data <= 1'b0;
        end
      end
      case (r_state)
        ST_SYNC: begin
          if (w_last_bit) begin
            r_sync_cnt <= r_sync_cnt + SW'(1);
          end
          if (w_go_active) begin
            r_state     <= ST_ACTIVE;
            r_sync_done <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          r_state <= ST_ACTIVE;
        end
        default: begin
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

  assign ready_out    = r_ready_out;
  assign out_serial   = r_out_serial;
  assign word_start   = r_word_start;
  assign sending_data = r_sending_data;
  assign sync_done    = r_sync_done;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Directed bench for paralelo_serial_param: default 8-bit MSB-first instance
// plus a 10-bit LSB-first instance.
module tb_paralelo_serial_param;

  logic       clk;
  logic       rst1, valid1, rdy1, ser1, ws1, sd1, sdn1;
  logic [7:0] data1;
  logic       rst2, valid2, rdy2, ser2, ws2, sd2, sdn2;
  logic [9:0] data2;

  int checks;
  int errors;

  logic [63:0] cap_ser, cap_ws, cap_sd, cap_rdy, cap_sdn;
  logic [7:0]  txq[$];

  paralelo_serial_param dut1 (
    .clk_32f      (clk),
    .reset        (rst1),
    .data_in      (data1),
    .valid_in     (valid1),
    .ready_out    (rdy1),
    .out_serial   (ser1),
    .word_start   (ws1),
    .sending_data (sd1),
    .sync_done    (sdn1)
  );

  paralelo_serial_param #(
    .WIDTH      (10),
    .IDLE_SYM   (10'h17C),
    .SYNC_WORDS (2),
    .MSB_FIRST  (1'b0)
  ) dut2 (
    .clk_32f      (clk),
    .reset        (rst2),
    .data_in      (data2),
    .valid_in     (valid2),
    .ready_out    (rdy2),
    .out_serial   (ser2),
    .word_start   (ws2),
    .sending_data (sd2),
    .sync_done    (sdn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run dut1 for n cycles, offering queued words and recording outputs.
  task automatic drive_cycles(input int n);
    logic xfer;
    for (int i = 0; i < n; i++) begin
      if (txq.size() > 0) begin
        valid1 = 1'b1;
        data1  = txq[0];
      end else begin
        valid1 = 1'b0;
        data1  = 8'h00;
      end
      xfer = valid1 && rdy1;
      @(posedge clk);
      #1;
      if (xfer) void'(txq.pop_front());
      cap_ser = {cap_ser[62:0], ser1};
      cap_ws  = {cap_ws[62:0],  ws1};
      cap_sd  = {cap_sd[62:0],  sd1};
      cap_rdy = {cap_rdy[62:0], rdy1};
      cap_sdn = {cap_sdn[62:0], sdn1};
    end
    if (txq.size() == 0) valid1 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ser1, ws1, sd1, sdn1, rdy1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dut1 got %b want 00000", {ser1, ws1, sd1, sdn1, rdy1});
    end
    checks++;
    if ({ser2, ws2, sd2, sdn2, rdy2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dut2 got %b want 00000", {ser2, ws2, sd2, sdn2, rdy2});
    end
    rst1 = 1'b0;
    checks++;
    if (ser1 !== 1'b0) begin
      errors++;
      $display("FAIL release_first_cycle got %b want 0", ser1);
    end
  endtask

  task automatic test_sync();
    drive_cycles(32);
    checks++;
    if (cap_ser[31:0] !== 32'hBCBCBCBC) begin
      errors++;
      $display("FAIL sync_serial got %h want bcbcbcbc", cap_ser[31:0]);
    end
    checks++;
    if (cap_ws[31:0] !== 32'h80808080) begin
      errors++;
      $display("FAIL sync_word_start got %h want 80808080", cap_ws[31:0]);
    end
    checks++;
    if (cap_rdy[31:0] !== 32'h00000001) begin
      errors++;
      $display("FAIL sync_ready got %h want 00000001", cap_rdy[31:0]);
    end
    checks++;
    if (cap_sdn[31:0] !== 32'h00000001) begin
      errors++;
      $display("FAIL sync_done got %h want 00000001", cap_sdn[31:0]);
    end
    checks++;
    if (cap_sd[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL sync_sending got %h want 0", cap_sd[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    txq.push_back(8'hA5);
    txq.push_back(8'h3C);
    drive_cycles(24);
    checks++;
    if (cap_ser[23:0] !== 24'hBCA53C) begin
      errors++;
      $display("FAIL b2b_serial got %h want bca53c", cap_ser[23:0]);
    end
    checks++;
    if (cap_sd[23:0] !== 24'h00FFFF) begin
      errors++;
      $display("FAIL b2b_sending got %h want 00ffff", cap_sd[23:0]);
    end
    checks++;
    if (cap_ws[23:0] !== 24'h808080) begin
      errors++;
      $display("FAIL b2b_word_start got %h want 808080", cap_ws[23:0]);
    end
    checks++;
    if (cap_rdy[23:0] !== 24'h0203FF) begin
      errors++;
      $display("FAIL b2b_ready got %h want 0203ff", cap_rdy[23:0]);
    end
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL b2b_drained got %0d want 0", txq.size());
    end
  endtask

  task automatic test_idle_insert();
    txq.push_back(8'hFF);
    drive_cycles(24);
    checks++;
    if (cap_ser[23:0] !== 24'hBCFFBC) begin
      errors++;
      $display("FAIL idle_serial got %h want bcffbc", cap_ser[23:0]);
    end
    checks++;
    if (cap_sd[23:0] !== 24'h00FF00) begin
      errors++;
      $display("FAIL idle_sending got %h want 00ff00", cap_sd[23:0]);
    end
  endtask

  task automatic test_backpressure();
    txq.push_back(8'h01);
    txq.push_back(8'h02);
    txq.push_back(8'h03);
    drive_cycles(40);
    checks++;
    if (cap_ser[39:0] !== 40'hBC010203BC) begin
      errors++;
      $display("FAIL bp_serial got %h want bc010203bc", cap_ser[39:0]);
    end
    checks++;
    if (cap_sd[39:0] !== 40'h00FFFFFF00) begin
      errors++;
      $display("FAIL bp_sending got %h want 00ffffff00", cap_sd[39:0]);
    end
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL bp_drained got %0d want 0", txq.size());
    end
  endtask

  task automatic test_reset_mid_word();
    txq.push_back(8'hA5);
    txq.push_back(8'h5A);
    drive_cycles(12);
    checks++;
    if (cap_ser[3:0] !== 4'hA) begin
      errors++;
      $display("FAIL mid_partial got %h want a", cap_ser[3:0]);
    end
    checks++;
    if (txq.size() != 0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold_full got q=%0d rdy=%b want q=0 rdy=0", txq.size(), rdy1);
    end
    rst1   = 1'b1;
    valid1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ser1, ws1, sd1, sdn1, rdy1} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_outs got %b want 00000", {ser1, ws1, sd1, sdn1, rdy1});
    end
    rst1 = 1'b0;
    drive_cycles(48);
    checks++;
    if (cap_ser[47:0] !== 48'hBCBCBCBCBCBC) begin
      errors++;
      $display("FAIL mid_resync_serial got %h want bcbcbcbcbcbc", cap_ser[47:0]);
    end
    checks++;
    if (cap_sd[47:0] !== 48'h0) begin
      errors++;
      $display("FAIL mid_lost_words got %h want 0", cap_sd[47:0]);
    end
    checks++;
    if (cap_sdn[47:0] !== 48'h1FFFF) begin
      errors++;
      $display("FAIL mid_sync_done got %h want 1ffff", cap_sdn[47:0]);
    end
  endtask

  task automatic test_param_lsb();
    logic [39:0] s2, w2, d2, r2, n2;
    logic [39:0] exp_ser, exp_ws, exp_sd;
    logic        pending, xfer;
    exp_ser = {10'h0FA, 10'h0FA, 10'h0FA, 10'h295};
    exp_ws  = {10'h200, 10'h200, 10'h200, 10'h200};
    exp_sd  = {10'h000, 10'h000, 10'h000, 10'h3FF};
    s2 = '0; w2 = '0; d2 = '0; r2 = '0; n2 = '0;
    rst2    = 1'b0;
    pending = 1'b1;
    for (int i = 0; i < 40; i++) begin
      valid2 = pending;
      data2  = 10'h2A5;
      xfer   = valid2 && rdy2;
      @(posedge clk);
      #1;
      if (xfer) pending = 1'b0;
      s2 = {s2[38:0], ser2};
      w2 = {w2[38:0], ws2};
      d2 = {d2[38:0], sd2};
      r2 = {r2[38:0], rdy2};
      n2 = {n2[38:0], sdn2};
    end
    valid2 = 1'b0;
    checks++;
    if (s2 !== exp_ser) begin
      errors++;
      $display("FAIL w10_serial got %h want %h", s2, exp_ser);
    end
    checks++;
    if (w2 !== exp_ws) begin
      errors++;
      $display("FAIL w10_word_start got %h want %h", w2, exp_ws);
    end
    checks++;
    if (d2 !== exp_sd) begin
      errors++;
      $display("FAIL w10_sending got %h want %h", d2, exp_sd);
    end
    checks++;
    if (r2 !== 40'h0000100FFF) begin
      errors++;
      $display("FAIL w10_ready got %h want 0000100fff", r2);
    end
    checks++;
    if (n2 !== 40'h00001FFFFF) begin
      errors++;
      $display("FAIL w10_sync_done got %h want 00001fffff", n2);
    end
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL w10_accepted got %b want 0", pending);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst1    = 1'b1;
    rst2    = 1'b1;
    valid1  = 1'b0;
    valid2  = 1'b0;
    data1   = 8'h00;
    data2   = 10'h000;
    cap_ser = '0;
    cap_ws  = '0;
    cap_sd  = '0;
    cap_rdy = '0;
    cap_sdn = '0;
    test_reset();
    test_sync();
    test_back_to_back();
    test_idle_insert();
    test_backpressure();
    test_reset_mid_word();
    test_param_lsb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
